issue_stage: RTL and testbench

ISSUE_STAGE -- requirements
Module: issue_stage

---
 rtl/issue_stage_pkg.sv | 33 +++
 rtl/issue_stage_scoreboard.sv | 45 ++++
 rtl/issue_stage.sv | 81 ++++++++
 tb/tb_issue_stage.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/issue_stage_pkg.sv
// Shared packages: the instruction format seen by the issue stage, and the
// common constants and classification helpers used around it.
package issue_inst_pkg;

  typedef struct packed {
    logic       valid;
    logic [4:0] src1;
    logic [4:0] src2;
    logic [4:0] dst;
    logic       reg_wen;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_muldiv;
  } decode_t;

endpackage

package issue_stage_pkg;
  import issue_inst_pkg::*;

  localparam int N_REG_DEFAULT = 32;

  function automatic logic is_mem(input decode_t d);
    return d.is_load | d.is_store;
  endfunction

  // Long-latency producers whose result arrives later through writeback.
  function automatic logic sets_busy(input decode_t d);
    return d.reg_wen && (d.dst != 5'd0) && (d.is_load || d.is_muldiv);
  endfunction

endpackage

// File: rtl/issue_stage_scoreboard.sv
// Busy-bit scoreboard: two set ports (issue), two clear ports (writeback),
// four source lookups. Register 0 is never busy.
module issue_stage_scoreboard #(
  parameter int N_REG = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic [1:0]      set_en,
  input  logic [1:0][4:0] set_rd,
  input  logic [1:0]      clr_en,
  input  logic [1:0][4:0] clr_rd,
  input  logic [3:0][4:0] qry_rd,
  output logic [3:0]      qry_busy
);

  logic [N_REG-1:0] busy_q;
  logic [N_REG-1:0] busy_nxt;

  // Clears are applied before sets so an issue in the same cycle wins.
  always_comb begin
    busy_nxt = busy_q;
    for (int i = 0; i < 2; i++) begin
      if (clr_en[i] && (int'(clr_rd[i]) < N_REG)) busy_nxt[clr_rd[i]] = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      if (set_en[i] && (int'(set_rd[i]) < N_REG)) busy_nxt[set_rd[i]] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)    busy_q <= '0;
    else if (flush) busy_q <= '0;
    else            busy_q <= busy_nxt;
  end

  always_comb begin
    qry_busy = '0;
    for (int q = 0; q < 4; q++) begin
      qry_busy[q] = (qry_rd[q] != 5'd0) && (int'(qry_rd[q]) < N_REG) && busy_q[qry_rd[q]];
    end
  end

endmodule

// File: rtl/issue_stage.sv
// In-order issue stage: picks up to two queue-head entries per cycle and
// registers them for execute. Dual issue is enabled by defining ISSUE_DUAL_EN.
module issue_stage
  import issue_inst_pkg::*;
  import issue_stage_pkg::*;
#(
  parameter int N_REG = N_REG_DEFAULT
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  decode_t [1:0]    q_out,
  input  logic             queue_empty,
  output logic [1:0]       issued_cnt,
  output decode_t [1:0]    ex_inst,
  output logic [1:0]       ex_valid,
  input  logic             ex_ready,
  input  logic [1:0]       wb_en,
  input  logic [1:0][4:0]  wb_rd
);

`ifdef ISSUE_DUAL_EN
  localparam bit DUAL_EN = 1'b1;
`else
  localparam bit DUAL_EN = 1'b0;
`endif

  decode_t    s0;
  decode_t    s1;
  logic [3:0] src_busy;
  logic       stalled;
  logic       raw_dep;
  logic       struct_blk;
  logic       dual_ok;
  logic       issue0;
  logic       issue1;

  assign s0 = q_out[0];
  assign s1 = q_out[1];

  always_comb begin
    stalled    = (ex_valid != 2'b00) && !ex_ready;
    issue0     = resetn && !flush && !stalled && !queue_empty && s0.valid &&
                 !src_busy[0] && !src_busy[1];
    raw_dep    = s0.reg_wen && (s0.dst != 5'd0) &&
                 ((s1.src1 == s0.dst) || (s1.src2 == s0.dst));
    struct_blk = (is_mem(s0) && is_mem(s1)) || (s0.is_muldiv && s1.is_muldiv) ||
                 s0.is_branch;
    dual_ok    = s1.valid && !src_busy[2] && !src_busy[3] && !raw_dep && !struct_blk;
    issue1     = DUAL_EN && issue0 && dual_ok;
    issued_cnt = issue1 ? 2'd2 : (issue0 ? 2'd1 : 2'd0);
  end

  issue_stage_scoreboard #(.N_REG(N_REG)) u_scoreboard (
    .clk      (clk),
    .resetn   (resetn),
    .flush    (flush),
    .set_en   ({issue1 && sets_busy(s1), issue0 && sets_busy(s0)}),
    .set_rd   ({s1.dst, s0.dst}),
    .clr_en   (wb_en),
    .clr_rd   (wb_rd),
    .qry_rd   ({s1.src2, s1.src1, s0.src2, s0.src1}),
    .qry_busy (src_busy)
  );

  // Issue -> execute boundary
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ex_valid <= 2'b00;
      ex_inst  <= '0;
    end else if (flush) begin
      ex_valid <= 2'b00;
      ex_inst  <= '0;
    end else if (!stalled) begin
      ex_valid   <= {issue1, issue0};
      ex_inst[0] <= issue0 ? s0 : '0;
      ex_inst[1] <= issue1 ? s1 : '0;
    end
  end

endmodule

// File: tb/tb_issue_stage.sv
// Scoreboard bench for issue_stage; expectations adapt to ISSUE_DUAL_EN.
module tb_issue_stage;
  import issue_inst_pkg::*;

`ifdef ISSUE_DUAL_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            flush = 1'b0;
  logic            queue_empty = 1'b1;
  logic            ex_ready = 1'b1;
  decode_t [1:0]   q_out;
  logic [1:0]      issued_cnt;
  decode_t [1:0]   ex_inst;
  logic [1:0]      ex_valid;
  logic [1:0]      wb_en;
  logic [1:0][4:0] wb_rd;

  typedef struct {
    string      name;
    logic [1:0] cnt;
    logic [1:0] exv;
    decode_t    i0;
    decode_t    i1;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  issue_stage dut (
    .clk         (clk),
    .resetn      (resetn),
    .flush       (flush),
    .q_out       (q_out),
    .queue_empty (queue_empty),
    .issued_cnt  (issued_cnt),
    .ex_inst     (ex_inst),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .wb_en       (wb_en),
    .wb_rd       (wb_rd)
  );

  function automatic decode_t op_add(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
    decode_t r;
    r = '0;
    r.valid = 1'b1; r.dst = d; r.src1 = a; r.src2 = b; r.reg_wen = 1'b1;
    return r;
  endfunction

  function automatic decode_t op_ld(input logic [4:0] d, input logic [4:0] a);
    decode_t r;
    r = op_add(d, a, 5'd0);
    r.is_load = 1'b1;
    return r;
  endfunction

  function automatic decode_t op_st(input logic [4:0] a, input logic [4:0] b);
    decode_t r;
    r = '0;
    r.valid = 1'b1; r.src1 = a; r.src2 = b; r.is_store = 1'b1;
    return r;
  endfunction

  function automatic decode_t op_br(input logic [4:0] a, input logic [4:0] b);
    decode_t r;
    r = '0;
    r.valid = 1'b1; r.src1 = a; r.src2 = b; r.is_branch = 1'b1;
    return r;
  endfunction

  // Monitor: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (issued_cnt !== e.cnt) begin
        failures++;
        $display("FAIL %s issued_cnt: got %0d expected %0d", e.name, issued_cnt, e.cnt);
      end
      checks++;
      if (ex_valid !== e.exv) begin
        failures++;
        $display("FAIL %s ex_valid: got %b expected %b", e.name, ex_valid, e.exv);
      end
      checks++;
      if (ex_inst[0] !== e.i0) begin
        failures++;
        $display("FAIL %s ex_inst0: got %h expected %h", e.name, ex_inst[0], e.i0);
      end
      checks++;
      if (ex_inst[1] !== e.i1) begin
        failures++;
        $display("FAIL %s ex_inst1: got %h expected %h", e.name, ex_inst[1], e.i1);
      end
    end
  end

  task automatic step(input string nm, input decode_t a, input decode_t b,
                      input logic qe, input logic rdy, input logic fl,
                      input logic [1:0] we, input logic [4:0] wr,
                      input logic [1:0] ecnt, input logic [1:0] eexv,
                      input decode_t e0, input decode_t e1);
    exp_t e;
    q_out[0] = a; q_out[1] = b;
    queue_empty = qe; ex_ready = rdy; flush = fl;
    wb_en = we; wb_rd[0] = wr; wb_rd[1] = 5'd0;
    e.name = nm; e.cnt = ecnt; e.exv = eexv; e.i0 = e0; e.i1 = e1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    decode_t    z;
    logic [1:0] c2;
    logic [1:0] v2;
    z  = '0;
    c2 = DUAL ? 2'd2 : 2'd1;
    v2 = DUAL ? 2'b11 : 2'b01;
    q_out = '0; wb_en = 2'b00; wb_rd = '0;
    @(posedge clk);
    #1;

    step("reset_hold", op_add(3,1,2), z, 1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 2'd0, 2'b00, z, z);
    resetn = 1'b1;

    step("dual_add", op_add(3,1,2), op_add(4,5,6), 1'b0, 1'b1, 1'b0, 2'b00, 5'd0, c2, 2'b00, z, z);
    step("dual_add_ex", z, z, 1'b1, 1'b1, 1'b0, 2'b00, 5'd0, 2'd0, v2,
         op_add(3,1,2), DUAL ? op_add(4,5,6) : z);

    step("load_raw", op_ld(5,1), op_add(6,5,1), 1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 2'd1, 2'b00, z, z);
    step("busy_wait0", op_add(6,5,1), z, 1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 2'd0, 2'b01, op_ld(5,1), z);
    step("busy_wait1", op_add(6,5,1), z, 1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 2'd0, 2'b00, z, z);
    step("busy_wb", op_add(6,5,1), z, 1'b0, 1'b1, 1'b0, 2'b01, 5'd5, 2'd0, 2'b00, z, z);
    step("busy_clear", op_add(6,5,1), z, 1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 2'd1, 2'b00, z, z);

    step("pre_stall", op_add(8,1,2), op_add(9,3,4), 1'b0, 1'b1, 1'b0, 2'b00, 5'd0, c2, 2'b01,
         op_add(6,5,1), z);
    for (int k = 0; k < 3; k++) begin
      step("stall", op_add(10,1,2), op_add(11,1,2), 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 2'd0, v2,
           op_add(8,1,2), DUAL ? op_add(9,3,4) : z);
    end
    step("stall_release", op_add(10,1,2), op_add(11,1,2), 1'b0, 1'b1, 1'b0, 2'b00, 5'd0, c2, v2,
         op_add(8,1,2), DUAL ? op_add(9,3,4) : z);
    step("resume_ex", z, z, 1'b1, 1'b1, 1'b0, 2'b00, 5'd0, 2'd0, v2,
         op_add(10,1,2), DUAL ? op_add(11,1,2) : z);

    step("two_stores", op_st(1,2), op_st(3,4), 1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 2'd1, 2'b00, z, z);
    step("branch_slot0", op_br(1,2), op_add(12,1,2), 1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 2'd1, 2'b01,
         op_st(1,2), z);

    step("load_r7", op_ld(7,1), z, 1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 2'd1, 2'b01, op_br(1,2), z);
    step("dep_r7_busy", op_add(13,7,1), z, 1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 2'd0, 2'b01, op_ld(7,1), z);
    step("pre_flush", op_add(14,1,2), z, 1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 2'd1, 2'b00, z, z);
    step("flush", op_add(2,1,1), op_add(20,1,1), 1'b0, 1'b1, 1'b1, 2'b00, 5'd0, 2'd0, 2'b01,
         op_add(14,1,2), z);
    step("after_flush_dep", op_add(13,7,1), z, 1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 2'd1, 2'b00, z, z);

    step("pre_reset", op_add(15,1,2), op_add(16,3,4), 1'b0, 1'b1, 1'b0, 2'b00, 5'd0, c2, 2'b01,
         op_add(13,7,1), z);
    step("stall_before_reset", op_add(17,1,2), z, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 2'd0, v2,
         op_add(15,1,2), DUAL ? op_add(16,3,4) : z);
    resetn = 1'b0;
    step("reset_mid_stall", op_add(17,1,2), z, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 2'd0, 2'b00, z, z);
    resetn = 1'b1;
    step("post_reset", op_add(18,1,2), z, 1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 2'd1, 2'b00, z, z);
    step("post_reset_ex", z, z, 1'b1, 1'b1, 1'b0, 2'b00, 5'd0, 2'd0, 2'b01, op_add(18,1,2), z);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
